aes_inv_data_path: RTL and testbench

//  Iterative AES-128 inverse cipher, one round per clock. It is the decrypt-side counterpart of
//  aes_data_path: it takes a ciphertext block plus the final (round-10) round key and returns the plaintext.
//  It rolls the key schedule backwards on the fly, so no round-key storage is needed.

---
 rtl/aes_inv_data_path_if.sv | 28 ++
 rtl/aes_inv_data_path.sv | 223 ++++++++++++++++++++++
 tb/tb_aes_inv_data_path.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_inv_data_path_if.sv
// Bundle of the start/data/result signals of the AES-128 inverse cipher.
//   i_dp_en        start request (sampled by the core only while idle)
//   i_cypher_text  ciphertext block, sampled with i_dp_en
//   i_rnd_key      round-10 key, sampled with i_dp_en
//   o_plain_text   decrypted block, held until the next completion
//   o_flag         one-cycle done pulse
//   o_busy         high while a block is in flight
// master: block requester; slave: the inverse-cipher core.
interface aes_inv_data_path_if #(
    parameter int unsigned RND_SIZE = 128
);
    logic                i_dp_en;
    logic [RND_SIZE-1:0] i_cypher_text;
    logic [RND_SIZE-1:0] i_rnd_key;
    logic [RND_SIZE-1:0] o_plain_text;
    logic                o_flag;
    logic                o_busy;

    modport master (
        output i_dp_en, i_cypher_text, i_rnd_key,
        input  o_plain_text, o_flag, o_busy
    );

    modport slave (
        input  i_dp_en, i_cypher_text, i_rnd_key,
        output o_plain_text, o_flag, o_busy
    );
endinterface

// File: rtl/aes_inv_data_path.sv
// Iterative AES-128 inverse cipher, one round per clock.
// Takes a ciphertext and the final (round-10) round key and produces the plaintext,
// rolling the key schedule backwards on the fly so no round keys are stored.
// Byte 0 of a block is bits [127:120]; the state is filled column-major.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus_if  slave side of aes_inv_data_path_if (start, ct, key, plaintext, flag, busy)
module aes_inv_data_path #(
    parameter int unsigned RND_SIZE = 128,
    parameter int unsigned WRD_SIZE = 32,
    parameter int unsigned NUM_BLK  = 4,
    parameter int unsigned CNT_SIZE = 4,
    parameter int unsigned NUM_RND  = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    aes_inv_data_path_if.slave  bus_if
);

    typedef enum logic [1:0] {StIdle, StRound, StFinal} fsm_e;

    // ---------------------------------------------------------------------------------------
    // GF(2^8) helpers, modulus x^8+x^4+x^3+x+1
    // ---------------------------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0 as AES requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] res;
        logic [7:0] base;
        res  = 8'h01;
        base = a;
        for (int i = 1; i < 8; i++) begin
            base = gf_mul(base, base);
            res  = gf_mul(res, base);
        end
        return res;
    endfunction

    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        logic [7:0] i;
        i = gf_inv(x);
        return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]}
               ^ 8'h63;
    endfunction

    // Inverse affine first, then field inverse.
    function automatic logic [7:0] aes_inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

    // Rows of the inverse MixColumns matrix are {0e,0b,0d,09} rotated right per row.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [7:0] rcon_of(input logic [CNT_SIZE-1:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // ---------------------------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------------------------
    fsm_e                fsm_q, fsm_d;
    logic [CNT_SIZE-1:0] cnt_q, cnt_d;
    logic [RND_SIZE-1:0] state_q, state_d;
    logic [RND_SIZE-1:0] key_q, key_d;
    logic [RND_SIZE-1:0] plain_q, plain_d;
    logic                flag_q, flag_d;
    logic                busy_q, busy_d;

    // ---------------------------------------------------------------------------------------
    // Round datapath
    // ---------------------------------------------------------------------------------------
    logic [RND_SIZE-1:0] isb_blk;   // InvSubBytes(InvShiftRows(state))
    logic [RND_SIZE-1:0] ark_blk;   // ... ^ previous round key
    logic [RND_SIZE-1:0] imc_blk;   // InvMixColumns of the above
    logic [RND_SIZE-1:0] key_prev;  // round key one step earlier in the schedule

    // Row r of the state rotates right by r, so output column c takes column c-r.
    for (genvar c = 0; c < NUM_BLK; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int unsigned Src = 4 * ((c + 4 - r) % 4) + r;
            localparam int unsigned Dst = 4 * c + r;
            assign isb_blk[127-8*Dst -: 8] = aes_inv_sbox(state_q[127-8*Src -: 8]);
        end
        assign imc_blk[127-32*c -: 32] = inv_mix_col(ark_blk[127-32*c -: 32]);
    end

    // Backwards key schedule: recover the earlier words first, then w0 needs the new w3.
    logic [WRD_SIZE-1:0] w0, w1, w2, w3;
    logic [WRD_SIZE-1:0] w0_n, w1_n, w2_n, w3_n;
    logic [WRD_SIZE-1:0] rot_w, sub_w;
    logic [CNT_SIZE-1:0] rcon_idx;

    assign {w0, w1, w2, w3} = key_q;
    assign w3_n     = w3 ^ w2;
    assign w2_n     = w2 ^ w1;
    assign w1_n     = w1 ^ w0;
    assign rot_w    = {w3_n[23:0], w3_n[31:24]};
    assign rcon_idx = cnt_q + CNT_SIZE'(1);

    for (genvar k = 0; k < 4; k++) begin : g_key_sbox
        assign sub_w[31-8*k -: 8] = aes_sbox(rot_w[31-8*k -: 8]);
    end

    assign w0_n     = w0 ^ sub_w ^ {rcon_of(rcon_idx), 24'h000000};
    assign key_prev = {w0_n, w1_n, w2_n, w3_n};
    assign ark_blk  = isb_blk ^ key_prev;

    // ---------------------------------------------------------------------------------------
    // Control
    // ---------------------------------------------------------------------------------------
    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        key_d   = key_q;
        plain_d = plain_q;
        flag_d  = 1'b0;
        busy_d  = busy_q;
        unique case (fsm_q)
            StIdle: begin
                if (bus_if.i_dp_en) begin
                    state_d = bus_if.i_cypher_text ^ bus_if.i_rnd_key;
                    key_d   = bus_if.i_rnd_key;
                    cnt_d   = CNT_SIZE'(NUM_RND - 1);
                    busy_d  = 1'b1;
                    fsm_d   = StRound;
                end
            end
            StRound: begin
                state_d = imc_blk;
                key_d   = key_prev;
                cnt_d   = cnt_q - CNT_SIZE'(1);
                if (cnt_q == CNT_SIZE'(1)) fsm_d = StFinal;
            end
            StFinal: begin
                plain_d = ark_blk;
                flag_d  = 1'b1;
                busy_d  = 1'b0;
                cnt_d   = '0;
                fsm_d   = StIdle;
            end
            default: fsm_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= StIdle;
            cnt_q   <= '0;
            state_q <= '0;
            key_q   <= '0;
            plain_q <= '0;
            flag_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            key_q   <= key_d;
            plain_q <= plain_d;
            flag_q  <= flag_d;
            busy_q  <= busy_d;
        end
    end

    assign bus_if.o_plain_text = plain_q;
    assign bus_if.o_flag       = flag_q;
    assign bus_if.o_busy       = busy_q;

endmodule

// File: tb/tb_aes_inv_data_path.sv
// Self-checking bench for aes_inv_data_path: known-answer vectors, back-to-back, abort,
// and randomized round trips against a table-driven AES model.
module tb_aes_inv_data_path;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    aes_inv_data_path_if bus_if ();

    aes_inv_data_path dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus_if.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sbox_t  [256];
    logic [7:0] isbox_t [256];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Carry-less polynomial product followed by reduction mod 0x11b.
    function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] prod;
        prod = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) prod = prod ^ (15'(a) << i);
        for (int k = 14; k >= 8; k--)
            if (prod[k]) prod = prod ^ (15'h11b << (k - 8));
        return prod[7:0];
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (tb_gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                       ^ inv[(i + 7) % 8] ^ c[i];
            sbox_t[a]  = s;
            isbox_t[s] = 8'(a);
        end
    endtask

    function automatic logic [7:0] tb_rcon(input int i);
        logic [7:0] r;
        r = 8'h01;
        for (int k = 1; k < i; k++) r = tb_gmul(r, 8'h02);
        return r;
    endfunction

    function automatic logic [31:0] key_core(input logic [31:0] w, input int i);
        logic [31:0] r;
        r = {w[23:0], w[31:24]};
        for (int k = 0; k < 4; k++) r[31-8*k -: 8] = sbox_t[r[31-8*k -: 8]];
        return r ^ {tb_rcon(i), 24'h0};
    endfunction

    task automatic model_encrypt(input logic [127:0] pt, input logic [127:0] k0,
                                 output logic [127:0] ct, output logic [127:0] k10);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [7:0]  a0, a1, a2, a3;
        for (int i = 0; i < 4; i++) w[i] = k0[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) tmp = key_core(tmp, i / 4);
            w[i] = w[i-4] ^ tmp;
        end
        for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int n = 0; n < 16; n++) s[n] = sbox_t[s[n]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (rnd < 10) begin
                    s[4*c]   = tb_gmul(a0, 8'h02) ^ tb_gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ tb_gmul(a1, 8'h02) ^ tb_gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ tb_gmul(a2, 8'h02) ^ tb_gmul(a3, 8'h03);
                    s[4*c+3] = tb_gmul(a0, 8'h03) ^ a1 ^ a2 ^ tb_gmul(a3, 8'h02);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[4*rnd + n/4][31-8*(n%4) -: 8];
        end
        for (int n = 0; n < 16; n++) ct[127-8*n -: 8] = s[n];
        k10 = {w[40], w[41], w[42], w[43]};
    endtask

    function automatic logic [127:0] model_decrypt(input logic [127:0] ct,
                                                   input logic [127:0] k10);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] pt;
        for (int i = 0; i < 4; i++) w[40+i] = k10[127-32*i -: 32];
        for (int i = 39; i >= 0; i--) begin
            tmp = w[i+3];
            if ((i + 4) % 4 == 0) tmp = key_core(tmp, (i + 4) / 4);
            w[i] = w[i+4] ^ tmp;
        end
        for (int n = 0; n < 16; n++) s[n] = ct[127-8*n -: 8] ^ w[40 + n/4][31-8*(n%4) -: 8];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4*c+r] = isbox_t[s[4*((c-r+4)%4)+r]];
            for (int n = 0; n < 16; n++) t[n] = t[n] ^ w[4*rnd + n/4][31-8*(n%4) -: 8];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (rnd > 0) begin
                    s[4*c]   = tb_gmul(a0, 8'h0e) ^ tb_gmul(a1, 8'h0b) ^ tb_gmul(a2, 8'h0d)
                               ^ tb_gmul(a3, 8'h09);
                    s[4*c+1] = tb_gmul(a0, 8'h09) ^ tb_gmul(a1, 8'h0e) ^ tb_gmul(a2, 8'h0b)
                               ^ tb_gmul(a3, 8'h0d);
                    s[4*c+2] = tb_gmul(a0, 8'h0d) ^ tb_gmul(a1, 8'h09) ^ tb_gmul(a2, 8'h0e)
                               ^ tb_gmul(a3, 8'h0b);
                    s[4*c+3] = tb_gmul(a0, 8'h0b) ^ tb_gmul(a1, 8'h0d) ^ tb_gmul(a2, 8'h09)
                               ^ tb_gmul(a3, 8'h0e);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
        end
        for (int n = 0; n < 16; n++) pt[127-8*n -: 8] = s[n];
        return pt;
    endfunction

    // ---------------- stimulus helpers ----------------
    // Returns the negedge index (counted from the start edge) at which o_flag is seen, 0 if none.
    task automatic wait_flag(input int first, output int n);
        n = 0;
        for (int i = first; i <= 20; i++) begin
            @(negedge clk);
            if (bus_if.o_flag) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic run_block(input logic [127:0] ct, input logic [127:0] key,
                             input logic [127:0] exp, input string tag);
        int n;
        @(negedge clk);
        bus_if.i_dp_en       = 1'b1;
        bus_if.i_cypher_text = ct;
        bus_if.i_rnd_key     = key;
        @(negedge clk);
        bus_if.i_dp_en = 1'b0;
        check_eq({tag, "_busy"}, 128'(bus_if.o_busy), 128'd1);
        wait_flag(2, n);
        check_eq({tag, "_latency"}, 128'(n), 128'd11);
        check_eq({tag, "_pt"}, bus_if.o_plain_text, exp);
    endtask

    localparam logic [127:0] T1_CT = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] T1_K  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] T1_PT = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] T2_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] T2_K  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] T2_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] T3_CT = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] T3_K  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    initial begin
        logic [127:0] pt, k0, ct, k10;
        int           pulses;
        int           pulse_at [2];
        logic [127:0] pulse_pt [2];

        bus_if.i_dp_en       = 1'b0;
        bus_if.i_cypher_text = '0;
        bus_if.i_rnd_key     = '0;
        build_tables();

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_pt", bus_if.o_plain_text, 128'd0);
        check_eq("rst_flag", 128'(bus_if.o_flag), 128'd0);
        check_eq("rst_busy", 128'(bus_if.o_busy), 128'd0);
        rst_n = 1'b1;

        // Known answers
        run_block(T1_CT, T1_K, T1_PT, "t1");
        @(negedge clk);
        check_eq("t1_flag_one_cycle", 128'(bus_if.o_flag), 128'd0);
        check_eq("t1_idle_busy", 128'(bus_if.o_busy), 128'd0);
        repeat (3) @(negedge clk);
        check_eq("t1_hold", bus_if.o_plain_text, T1_PT);
        run_block(T2_CT, T2_K, T2_PT, "t2");
        run_block(T3_CT, T3_K, 128'd0, "t3");

        // Back-to-back with en held high; inputs change while busy and must be ignored
        @(negedge clk);
        bus_if.i_dp_en       = 1'b1;
        bus_if.i_cypher_text = T1_CT;
        bus_if.i_rnd_key     = T1_K;
        @(negedge clk);
        bus_if.i_cypher_text = T2_CT;
        bus_if.i_rnd_key     = T2_K;
        pulses = 0;
        pulse_at[0] = 0; pulse_at[1] = 0;
        pulse_pt[0] = '0; pulse_pt[1] = '0;
        for (int i = 2; i <= 30; i++) begin
            @(negedge clk);
            if (i == 12) bus_if.i_dp_en = 1'b0;
            if (bus_if.o_flag) begin
                if (pulses < 2) begin
                    pulse_at[pulses] = i;
                    pulse_pt[pulses] = bus_if.o_plain_text;
                end
                pulses++;
            end
        end
        check_eq("t4_pulses", 128'(pulses), 128'd2);
        check_eq("t4_first_at", 128'(pulse_at[0]), 128'd11);
        check_eq("t4_second_at", 128'(pulse_at[1]), 128'd22);
        check_eq("t4_first_pt", pulse_pt[0], T1_PT);
        check_eq("t4_second_pt", pulse_pt[1], T2_PT);

        // Abort mid-block
        @(negedge clk);
        bus_if.i_dp_en       = 1'b1;
        bus_if.i_cypher_text = T1_CT;
        bus_if.i_rnd_key     = T1_K;
        @(negedge clk);
        bus_if.i_dp_en = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("t5_busy", 128'(bus_if.o_busy), 128'd0);
        check_eq("t5_flag", 128'(bus_if.o_flag), 128'd0);
        check_eq("t5_pt", bus_if.o_plain_text, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus_if.o_flag) pulses++;
        end
        check_eq("t5_no_flag", 128'(pulses), 128'd0);
        check_eq("t5_pt_after", bus_if.o_plain_text, 128'd0);
        run_block(T1_CT, T1_K, T1_PT, "t5_rerun");

        // Random round trips: encrypt with the model, decrypt with the DUT
        for (int k = 0; k < 1000; k++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            k0 = {$urandom, $urandom, $urandom, $urandom};
            model_encrypt(pt, k0, ct, k10);
            run_block(ct, k10, pt, "t6_loop");
        end

        // Random ciphertext / round-10 key pairs against the inverse model
        for (int k = 0; k < 100; k++) begin
            ct  = {$urandom, $urandom, $urandom, $urandom};
            k10 = {$urandom, $urandom, $urandom, $urandom};
            run_block(ct, k10, model_decrypt(ct, k10), "t7_rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
